pwm_duty_ramp: RTL and testbench

Duty-cycle front end that sits directly upstream of the PWM core and drives its duty input. It accepts target duty values over a valid/ready handshake. It slews its duty output toward the target by a programmable step, and only changes it at PWM period boundaries so that no period is ever truncated. It keeps an internal mirror of the PWM core's counter: same width, same enable and wrap rules, same clock.

---
 rtl/pwm_duty_ramp.sv | 90 +++++++++
 tb/tb_pwm_duty_ramp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle slew front end for the PWM core: accepts target duties and moves
// the duty output toward them only at PWM period boundaries.
module pwm_duty_ramp #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [WIDTH-1:0]  tgt_duty,
  input  logic [STEP_W-1:0] step,
  input  logic              ramp_en,
  output logic [WIDTH-1:0]  duty,
  output logic              busy,
  output logic              period_start
);

  // Handshake: a transfer happens on any rising clk edge with tgt_valid=1;
  // tgt_ready is 1 whenever reset is not asserted, so the source never stalls.

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t             state;
  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   target_q;

  logic               boundary;
  logic signed [WIDTH:0] diff;
  logic [WIDTH:0]     mag;
  logic [STEP_W-1:0]  eff_step;
  logic [WIDTH:0]     step_ext;
  logic [WIDTH-1:0]   ramp_duty;
  logic [WIDTH-1:0]   duty_nxt;
  logic [WIDTH-1:0]   target_nxt;

  assign tgt_ready = ~rst;
  assign busy      = (state == RAMP);

  // Boundary mirrors the PWM core's wrap, so a new duty takes effect at count 0.
  assign boundary = enable && (cnt == CNT_MAX);

  assign diff     = $signed({1'b0, target_q}) - $signed({1'b0, duty});
  assign mag      = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
  assign eff_step = (step == '0) ? STEP_W'(1) : step;
  assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, eff_step};

  always_comb begin
    ramp_duty = duty;
    if (!ramp_en || (mag <= step_ext)) begin
      ramp_duty = target_q;
    end else if (diff[WIDTH]) begin
      ramp_duty = duty - step_ext[WIDTH-1:0];
    end else begin
      ramp_duty = duty + step_ext[WIDTH-1:0];
    end
  end

  // The boundary update uses the old target; a same-edge transfer only
  // affects the stored target and the next-state comparison.
  always_comb begin
    target_nxt = tgt_valid ? tgt_duty : target_q;
    duty_nxt   = duty;
    if (!enable) begin
      duty_nxt = target_nxt;
    end else if (boundary && (state == RAMP)) begin
      duty_nxt = ramp_duty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      target_q     <= '0;
      duty         <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= enable ? cnt + 1'b1 : '0;
      period_start <= boundary;
      target_q     <= target_nxt;
      duty         <= duty_nxt;
      state        <= (duty_nxt != target_nxt) ? RAMP : IDLE;
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: directed scenarios plus randomized
// traffic, compared cycle by cycle against an integer reference model.
module tb_pwm_duty_ramp;

  localparam int W    = 8;
  localparam int SW   = 5;
  localparam int MAXV = (1 << W) - 1;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          tgt_valid;
  logic          tgt_ready;
  logic [W-1:0]  tgt_duty;
  logic [SW-1:0] step;
  logic          ramp_en;
  logic [W-1:0]  duty;
  logic          busy;
  logic          period_start;

  pwm_duty_ramp #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .tgt_valid    (tgt_valid),
    .tgt_ready    (tgt_ready),
    .tgt_duty     (tgt_duty),
    .step         (step),
    .ramp_en      (ramp_en),
    .duty         (duty),
    .busy         (busy),
    .period_start (period_start)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int m_cnt;
  int m_tgt;
  int m_duty;
  int m_ps;

  int n_checks;
  int n_pass;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_tgt  = 0;
    m_duty = 0;
    m_ps   = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs present at the edge.
  task automatic model_edge();
    int d;
    int es;
    int bnd;
    bnd = (enable && m_cnt == MAXV) ? 1 : 0;
    if (!enable) begin
      if (tgt_valid) m_tgt = int'(tgt_duty);
      m_duty = m_tgt;
    end else begin
      if (bnd == 1 && m_duty != m_tgt) begin
        d  = m_tgt - m_duty;
        es = (step == 0) ? 1 : int'(step);
        if (!ramp_en || (d < 0 ? -d : d) <= es) m_duty = m_tgt;
        else m_duty = m_duty + ((d > 0) ? es : -es);
      end
      if (tgt_valid) m_tgt = int'(tgt_duty);
    end
    m_cnt = enable ? (m_cnt + 1) % (MAXV + 1) : 0;
    m_ps  = bnd;
  endtask

  task automatic check_outputs();
    check_val("duty", int'(duty), m_duty);
    check_val("busy", int'(busy), (m_duty != m_tgt) ? 1 : 0);
    check_val("period_start", int'(period_start), m_ps);
    check_val("tgt_ready", int'(tgt_ready), 1);
  endtask

  // driver tasks
  task automatic step_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic xfer(input int d);
    tgt_valid = 1'b1;
    tgt_duty  = W'(d);
    step_cycle();
    tgt_valid = 1'b0;
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_duty", int'(duty), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_period_start", int'(period_start), 0);
    tgt_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_hold_duty", int'(duty), 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      tgt_valid = ($urandom_range(0, 47) == 0);
      tgt_duty  = W'($urandom_range(0, MAXV));
      step_cycle();
    end
    tgt_valid = 1'b0;
  endtask

  initial begin
    int guard;
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    enable    = 1'b0;
    tgt_valid = 1'b0;
    tgt_duty  = '0;
    step      = '0;
    ramp_en   = 1'b0;
    model_reset();
    #1;
    check_val("init_duty", int'(duty), 0);
    check_val("init_busy", int'(busy), 0);
    check_val("init_period_start", int'(period_start), 0);
    #2;
    rst = 1'b0;
    #1;
    check_val("init_ready", int'(tgt_ready), 1);

    // ramp up 0 -> 100 by 10
    enable  = 1'b1;
    ramp_en = 1'b1;
    step    = SW'(10);
    xfer(100);
    run(256 * 11);
    check_val("ramp_up_final", int'(duty), 100);

    // no overshoot, then step 0 acting as 1
    xfer(95);
    run(300);
    check_val("no_overshoot", int'(duty), 95);
    step = '0;
    xfer(98);
    run(256 * 4);
    check_val("step_zero_final", int'(duty), 98);

    // retarget mid-ramp
    ramp_en = 1'b0;
    xfer(0);
    run(300);
    ramp_en = 1'b1;
    step    = SW'(16);
    xfer(200);
    guard = 0;
    while (m_duty != 48 && guard < 5000) begin
      step_cycle();
      guard++;
    end
    check_val("reach_48", m_duty, 48);
    xfer(20);
    run(256 * 3);
    check_val("retarget_final", int'(duty), 20);

    // transfer on the same edge as a boundary
    xfer(120);
    guard = 0;
    while (m_cnt != MAXV && guard < 300) begin
      step_cycle();
      guard++;
    end
    check_val("reach_boundary", m_cnt, MAXV);
    xfer(30);
    check_val("same_edge_old_target", int'(duty), 36);
    run(256 * 2);

    // jump mode
    ramp_en = 1'b0;
    xfer(0);
    run(300);
    run(100);
    xfer(200);
    check_val("jump_pending", int'(duty), 0);
    run(200);
    check_val("jump_done", int'(duty), 200);

    // disabled
    enable = 1'b0;
    xfer(77);
    check_val("disabled_duty", int'(duty), 77);
    run(10);
    enable = 1'b1;
    run(300);

    // reset mid-ramp
    xfer(60);
    run(300);
    ramp_en = 1'b1;
    step    = SW'(10);
    xfer(150);
    run(300);
    check_val("pre_reset_duty", int'(duty), 70);
    async_reset();
    run(600);
    check_val("post_reset_duty", int'(duty), 0);

    // randomized traffic
    for (int s = 0; s < 40; s++) begin
      enable  = ($urandom_range(0, 7) != 0);
      ramp_en = ($urandom_range(0, 3) != 0);
      step    = SW'($urandom_range(0, (1 << SW) - 1));
      run_rand(400);
      if ($urandom_range(0, 9) == 0) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
